// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a shared 8-digit seven-segment display with minimum hold time.
// Every ownership change passes through one blanked SWITCH cycle.
module seg_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DIGITS      = 8,
    parameter int HOLD_CYCLES = 200_000_000
) (
    input  logic                        clock_100Mhz,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*4*DIGITS-1:0] frame_in,
    output logic [NUM_REQ-1:0]          grant,
    output logic [4*DIGITS-1:0]         frame_out,
    output logic                        frame_valid,
    output logic                        blank,
    output logic                        switch_pulse,
    output logic [1:0]                  fsm_state
);
    localparam int FW = 4 * DIGITS;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, SWITCH = 2'd2} state_t;

    state_t             state, next_state;
    logic [IW-1:0]      rr_ptr, ptr_next, pick_idx;
    logic               pick_valid;
    logic [HW-1:0]      hold_cnt, hold_next;
    logic [NUM_REQ-1:0] owner_mask, grant_next;
    logic [FW-1:0]      frame_next;
    logic               valid_next, pulse_next;

    assign fsm_state  = state;
    // rr_ptr doubles as the current owner index while in OWN.
    assign owner_mask = NUM_REQ'(1) << rr_ptr;

    // Scan rr_ptr+1 .. rr_ptr (mod NUM_REQ): the last owner is considered last.
    always_comb begin
        pick_idx   = rr_ptr;
        pick_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_valid && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick_idx   = IW'((int'(rr_ptr) + i) % NUM_REQ);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (pick_valid) next_state = OWN;
            OWN:    if (!req[rr_ptr] ||
                        (hold_cnt == HOLD_MAX && |(req & ~owner_mask)))
                        next_state = SWITCH;
            SWITCH: next_state = pick_valid ? OWN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        ptr_next = rr_ptr;
        if (state != OWN && next_state == OWN) ptr_next = pick_idx;
        valid_next = (next_state == OWN);
        grant_next = valid_next ? (NUM_REQ'(1) << ptr_next) : '0;
        pulse_next = valid_next && (state != OWN);
        frame_next = valid_next ? frame_in[ptr_next*FW +: FW] : frame_out;
        hold_next  = '0;
        if (state == OWN && next_state == OWN)
            hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= IW'(NUM_REQ - 1);
            hold_cnt     <= '0;
            grant        <= '0;
            frame_out    <= '0;
            frame_valid  <= 1'b0;
            blank        <= 1'b1;
            switch_pulse <= 1'b0;
        end else begin
            rr_ptr       <= ptr_next;
            hold_cnt     <= hold_next;
            grant        <= grant_next;
            frame_out    <= frame_next;
            frame_valid  <= valid_next;
            blank        <= !valid_next;
            switch_pulse <= pulse_next;
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=8: reset, grant, preemption,
// round-robin rotation, voluntary release, idle return and asynchronous reset.
module tb_seg_display_arbiter;
    localparam int NR = 4;
    localparam int FW = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*FW-1:0]  frame_in = '0;
    logic [NR-1:0]     grant;
    logic [FW-1:0]     frame_out;
    logic              frame_valid, blank, switch_pulse;
    logic [1:0]        fsm_state;

    int total = 0;
    int bad = 0;

    seg_display_arbiter #(.NUM_REQ(NR), .DIGITS(8), .HOLD_CYCLES(8)) dut (
        .clock_100Mhz(clk), .reset_n(reset_n), .req(req), .frame_in(frame_in),
        .grant(grant), .frame_out(frame_out), .frame_valid(frame_valid),
        .blank(blank), .switch_pulse(switch_pulse), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic sp);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".valid"}, 32'(frame_valid), 32'(g != 0));
        chk({tag, ".blank"}, 32'(blank), 32'(g == 0));
        chk({tag, ".pulse"}, 32'(switch_pulse), 32'(sp));
    endtask

    function automatic logic [31:0] fr(input int i);
        return frame_in[i*FW +: FW];
    endfunction

    initial begin
        frame_in = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};

        // Reset held: inputs wiggle, outputs stay at reset values.
        for (int k = 0; k < 3; k++) begin
            req = 4'($urandom_range(1, 15));
            step();
            chk_out("rst_hold", 4'b0000, 1'b0);
            chk("rst_hold.frame", frame_out, 32'h0);
            chk("rst_hold.state", 32'(fsm_state), 32'd0);
        end
        req = '0;
        reset_n = 1'b1;
        step();
        chk_out("idle", 4'b0000, 1'b0);

        // First grant to requester 0, frame valid in the first OWN cycle.
        req = 4'b0001;
        step();
        chk_out("grant0", 4'b0001, 1'b1);
        chk("grant0.frame", frame_out, 32'h1234_5678);
        chk("grant0.state", 32'(fsm_state), 32'd1);
        step();
        chk_out("own0_c1", 4'b0001, 1'b0);

        // Requester 1 waits for owner 0's hold to expire.
        req = 4'b0011;
        for (int k = 2; k < 8; k++) begin
            step();
            chk_out("own0_hold", 4'b0001, 1'b0);
        end
        step();
        chk_out("sw0to1", 4'b0000, 1'b0);
        chk("sw0to1.state", 32'(fsm_state), 32'd2);
        step();
        chk_out("grant1", 4'b0010, 1'b1);
        chk("grant1.frame", frame_out, 32'hBBBB_0001);

        // Owned frame changes pass through one cycle later.
        frame_in[1*FW +: FW] = 32'hBEEF_0001;
        chk("pass.before", frame_out, 32'hBBBB_0001);

        // All requesting: rotate 2, 3, 0, then back to 1.
        req = 4'b1111;
        step();
        chk("pass.after", frame_out, 32'hBEEF_0001);
        chk_out("own1_c1", 4'b0010, 1'b0);
        for (int k = 2; k < 8; k++) begin
            step();
            chk_out("own1_hold", 4'b0010, 1'b0);
        end
        step();
        chk_out("sw1", 4'b0000, 1'b0);
        for (int o = 2; o <= 4; o++) begin
            step();
            chk_out("rr_entry", 4'(1 << (o % 4)), 1'b1);
            chk("rr_entry.frame", frame_out, fr(o % 4));
            for (int k = 1; k < 8; k++) begin
                step();
                chk_out("rr_hold", 4'(1 << (o % 4)), 1'b0);
            end
            step();
            chk_out("rr_blank", 4'b0000, 1'b0);
        end
        step();
        chk_out("rr_wrap1", 4'b0010, 1'b1);

        // Owner 1 releases in hold cycle 3 while requester 2 waits.
        step();
        step();
        step();
        chk_out("own1_c3", 4'b0010, 1'b0);
        req = 4'b0100;
        step();
        chk_out("rel_sw", 4'b0000, 1'b0);
        step();
        chk_out("rel_grant2", 4'b0100, 1'b1);
        chk("rel_grant2.frame", frame_out, 32'hCCCC_0002);

        // Owner drops with nobody else pending: SWITCH then IDLE.
        req = 4'b0000;
        step();
        chk_out("drop_sw", 4'b0000, 1'b0);
        chk("drop_sw.state", 32'(fsm_state), 32'd2);
        step();
        chk_out("drop_idle", 4'b0000, 1'b0);
        chk("drop_idle.state", 32'(fsm_state), 32'd0);
        step();
        chk_out("idle_stay", 4'b0000, 1'b0);

        // Sole requester keeps ownership past hold expiry.
        req = 4'b0100;
        step();
        chk_out("solo_entry", 4'b0100, 1'b1);
        for (int k = 1; k < 12; k++) begin
            step();
            chk_out("solo_hold", 4'b0100, 1'b0);
        end

        // Asynchronous reset mid-cycle.
        #2 reset_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 1'b0);
        chk("async_rst.frame", frame_out, 32'h0);
        req = 4'b0110;
        step();
        reset_n = 1'b1;
        step();
        chk_out("post_rst", 4'b0010, 1'b1);
        chk("post_rst.frame", frame_out, 32'hBEEF_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
